// File: rtl/param_reg_file.sv
// Parameterised two-read/one-write register file with registered write-select and written-since-reset flags.
// Optional macro PARAM_REG_FILE_BYPASS_EN forwards same-cycle write data to the read ports.
module param_reg_file #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4,
    parameter int ZERO_R0 = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_W-1:0]      SrcReg1,
    input  logic [ADDR_W-1:0]      SrcReg2,
    input  logic [ADDR_W-1:0]      DstReg,
    input  logic                   WriteReg,
    input  logic [DATA_W-1:0]      DstData,
    output logic [DATA_W-1:0]      SrcData1,
    output logic [DATA_W-1:0]      SrcData2,
    output logic [(2**ADDR_W)-1:0] Wordline,
    output logic [(2**ADDR_W)-1:0] Written
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs_q    [DEPTH];
    logic [DATA_W-1:0] regs_d    [DEPTH];
    logic [DEPTH-1:0]  wordline_q;
    logic [DEPTH-1:0]  wordline_d;
    logic [DEPTH-1:0]  written_q;
    logic [DEPTH-1:0]  written_d;
    logic              r0_write_s;

    function automatic logic [DEPTH-1:0] one_hot(input logic [ADDR_W-1:0] idx);
        logic [DEPTH-1:0] sel;
        sel      = '0;
        sel[idx] = 1'b1;
        return sel;
    endfunction

    // Effective write select: empty when disabled or when a hard-wired register 0 is targeted.
    always_comb begin
        r0_write_s = (ZERO_R0 != 0) && (DstReg == '0);
        if (WriteReg && !r0_write_s) begin
            wordline_d = one_hot(DstReg);
        end else begin
            wordline_d = '0;
        end
        written_d = written_q | wordline_d;
    end

    // Next contents: only the selected register takes the write data.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wordline_d[i]) begin
                regs_d[i] = DstData;
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            wordline_q <= '0;
            written_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            wordline_q <= wordline_d;
            written_q  <= written_d;
        end
    end

    // Combinational read ports; register 0 is forced to zero when hard-wired.
    always_comb begin
        if ((ZERO_R0 != 0) && (SrcReg1 == '0)) begin
            SrcData1 = '0;
        end else begin
            SrcData1 = regs_q[SrcReg1];
        end
        if ((ZERO_R0 != 0) && (SrcReg2 == '0)) begin
            SrcData2 = '0;
        end else begin
            SrcData2 = regs_q[SrcReg2];
        end
`ifdef PARAM_REG_FILE_BYPASS_EN
        // wordline_d is already empty for suppressed writes, so only the reset gate is needed here.
        if (!rst && (wordline_d != '0) && (SrcReg1 == DstReg)) begin
            SrcData1 = DstData;
        end else begin
            SrcData1 = SrcData1;
        end
        if (!rst && (wordline_d != '0) && (SrcReg2 == DstReg)) begin
            SrcData2 = DstData;
        end else begin
            SrcData2 = SrcData2;
        end
`endif
    end

    assign Wordline = wordline_q;
    assign Written  = written_q;

endmodule

// File: tb/tb_param_reg_file.sv
// Directed self-checking bench for param_reg_file: default 16x16 instance plus a 32-bit/32-entry instance.
module tb_param_reg_file;

    logic        clk;
    logic        rst;
    logic [3:0]  src1, src2, dst;
    logic        we;
    logic [15:0] wdata;
    logic [15:0] rd1, rd2, wl, wr;

    logic [4:0]  src1_w, src2_w, dst_w;
    logic        we_w;
    logic [31:0] wdata_w;
    logic [31:0] rd1_w, rd2_w, wl_w, wr_w;

    int checks;
    int failures;

    param_reg_file u_dut (
        .clk(clk), .rst(rst), .SrcReg1(src1), .SrcReg2(src2), .DstReg(dst),
        .WriteReg(we), .DstData(wdata), .SrcData1(rd1), .SrcData2(rd2),
        .Wordline(wl), .Written(wr)
    );

    param_reg_file #(.DATA_W(32), .ADDR_W(5), .ZERO_R0(1)) u_dut_w (
        .clk(clk), .rst(rst), .SrcReg1(src1_w), .SrcReg2(src2_w), .DstReg(dst_w),
        .WriteReg(we_w), .DstData(wdata_w), .SrcData1(rd1_w), .SrcData2(rd2_w),
        .Wordline(wl_w), .Written(wr_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] exp_old;
        checks   = 0;
        failures = 0;
        rst  = 1'b1;
        src1 = 4'd5; src2 = 4'd5; dst = 4'd5; we = 1'b1; wdata = 16'hABCD;
        src1_w = 5'd31; src2_w = 5'd0; dst_w = 5'd31; we_w = 1'b1; wdata_w = 32'h1234_5678;

        // Writes requested during reset must be ignored, and no bypass.
        step();
        step();
        check("rst_rd1", rd1, 64'h0);
        check("rst_rd2", rd2, 64'h0);
        check("rst_wl", wl, 64'h0);
        check("rst_written", wr, 64'h0);
        check("rst_w_rd1", rd1_w, 64'h0);

        we = 1'b0; we_w = 1'b0;
        rst = 1'b0;
        #1;

        // Basic write then read next cycle.
        dst = 4'd5; wdata = 16'hBEEF; we = 1'b1;
        step();
        we = 1'b0; src1 = 4'd5;
        #1;
        check("wr5_rd1", rd1, 64'hBEEF);
        check("wr5_written", wr, 64'h0020);
        check("wr5_wl", wl, 64'h0020);
        step();
        check("idle_wl", wl, 64'h0);
        check("idle_written", wr, 64'h0020);

        // Writes to register 0 are suppressed.
        dst = 4'd0; wdata = 16'h1234; we = 1'b1; src1 = 4'd0;
        step();
        we = 1'b0;
        #1;
        check("r0_rd1", rd1, 64'h0);
        check("r0_wl", wl, 64'h0);
        check("r0_written", wr, 64'h0020);

        // Same-cycle read of the write target.
        dst = 4'd3; wdata = 16'h0011; we = 1'b1;
        step();
        dst = 4'd3; wdata = 16'h00AA; we = 1'b1; src2 = 4'd3;
        #1;
`ifdef PARAM_REG_FILE_BYPASS_EN
        exp_old = 16'h00AA;
`else
        exp_old = 16'h0011;
`endif
        check("same_cyc_rd2", rd2, {48'h0, exp_old});
        step();
        we = 1'b0;
        #1;
        check("after_rd2", rd2, 64'h00AA);
        check("wl_r3", wl, 64'h0008);

        // Back-to-back writes to one register: last wins.
        dst = 4'd7; wdata = 16'h1111; we = 1'b1;
        step();
        wdata = 16'h2222;
        step();
        we = 1'b0; src1 = 4'd7;
        #1;
        check("b2b_rd1", rd1, 64'h2222);

        // Fill all registers back-to-back, then read through both ports.
        for (int i = 0; i < 16; i++) begin
            dst = i[3:0]; wdata = 16'h1000 + i[15:0]; we = 1'b1;
            step();
        end
        check("fill_wl", wl, 64'h8000);
        we = 1'b0;
        for (int i = 0; i < 16; i++) begin
            src1 = i[3:0];
            src2 = 4'd15 - i[3:0];
            #1;
            check("fill_rd1", rd1, (i == 0) ? 64'h0 : 64'h1000 + i);
            check("fill_rd2", rd2, (i == 15) ? 64'h0 : 64'h1000 + (15 - i));
        end
        check("fill_written", wr, 64'hFFFE);

        // Wide instance: top register.
        dst_w = 5'd31; wdata_w = 32'hDEADBEEF; we_w = 1'b1; src1_w = 5'd31;
        step();
        we_w = 1'b0;
        #1;
        check("w_rd1", rd1_w, 64'hDEADBEEF);
        check("w_wl", wl_w, 64'h8000_0000);
        check("w_written", wr_w, 64'h8000_0000);

        // Asynchronous reset mid-period clears everything before the next edge.
        src1 = 4'd5; src2 = 4'd9;
        #1;
        check("pre_rst_rd1", rd1, 64'h1005);
        rst = 1'b1;
        #1;
        check("arst_rd1", rd1, 64'h0);
        check("arst_rd2", rd2, 64'h0);
        check("arst_wl", wl, 64'h0);
        check("arst_written", wr, 64'h0);
        check("arst_w_rd1", rd1_w, 64'h0);
        check("arst_w_written", wr_w, 64'h0);

        // Held reset with a pending write: ignored, no bypass.
        dst = 4'd9; wdata = 16'h5A5A; we = 1'b1; src2 = 4'd9;
        #1;
        check("rst_nobypass", rd2, 64'h0);
        step();
        check("rst_hold_written", wr, 64'h0);

        // First edge after release accepts the write.
        rst = 1'b0;
        step();
        we = 1'b0;
        #1;
        check("post_rst_rd2", rd2, 64'h5A5A);
        check("post_rst_written", wr, 64'h0200);
        check("post_rst_wl", wl, 64'h0200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/param_reg_file.md
PARAM_REG_FILE -- requirements
Module: param_reg_file

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning bit width of each register.
REQ-002 SHALL have parameter ADDR_W, default 4, meaning register index width; depth is 2**ADDR_W.
REQ-003 SHALL have parameter ZERO_R0, default 1, meaning when 1 register 0 reads 0 and ignores writes.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port SrcReg1  input  ADDR_W  read port 1 index.
REQ-007 SHALL have port SrcReg2  input  ADDR_W  read port 2 index.
REQ-008 SHALL have port DstReg  input  ADDR_W  write index.
REQ-009 SHALL have port WriteReg  input  1  write enable.
REQ-010 SHALL have port DstData  input  DATA_W  write data.
REQ-011 SHALL have port SrcData1  output  DATA_W  read port 1 data.
REQ-012 SHALL have port SrcData2  output  DATA_W  read port 2 data.
REQ-013 SHALL have port Wordline  output  2**ADDR_W  registered one-hot copy of the last accepted write's select lines.
REQ-014 SHALL have port Written  output  2**ADDR_W  per-register sticky flag, set once a register has been written since reset.

Function
REQ-015 SHALL decode DstReg to a 2**ADDR_W one-hot select; select is all-zero when WriteReg=0.
REQ-016 SHALL, on a rising clk edge with WriteReg=1, load DstData into register DstReg; other registers hold.
REQ-017 SHALL, when ZERO_R0=1 and DstReg=0, suppress the write, leave Wordline=0 and Written[0]=0 for that cycle.
REQ-018 SHALL present reads combinationally from register contents (zero-cycle read latency).
REQ-019 SHALL return 0 on any read port addressing register 0 when ZERO_R0=1.
REQ-020 SHALL update Wordline each rising edge to the effective one-hot select of that cycle (all-zero if no write accepted).
REQ-021 SHALL set Written[DstReg] on every accepted write; bits never clear except on reset.
REQ-022 SHALL allow both read ports to address the same register, including the write target, in one cycle.
REQ-023 SHALL accept back-to-back writes every cycle, to the same or different registers; last write wins.

Reset
REQ-024 SHALL, while rst=1, asynchronously force all registers, Wordline and Written to 0, independent of clk.
REQ-025 SHALL ignore WriteReg while rst=1; first write is accepted on the first rising edge after rst deasserts.
REQ-026 SHALL drive SrcData1/SrcData2 to 0 during reset (contents are 0), with bypass disabled during reset.

Configuration
REQ-027 SHALL, with macro PARAM_REG_FILE_BYPASS_EN defined, forward DstData to SrcDataN when WriteReg=1, rst=0, SrcRegN==DstReg and the write is not suppressed by REQ-017.
REQ-028 SHALL, without PARAM_REG_FILE_BYPASS_EN, return the pre-write register value on a same-cycle read of the write target; new value visible the following cycle.

Verification
REQ-029 SHALL cover: reset, write DstReg=5 DstData=16'hBEEF, next cycle SrcReg1=5 -> SrcData1=16'hBEEF, Written=16'h0020, Wordline=16'h0020 after the edge.
REQ-030 SHALL cover: ZERO_R0=1, write DstReg=0 DstData=16'h1234, then read SrcReg1=0 -> SrcData1=0, Wordline=0, Written[0]=0.
REQ-031 SHALL cover: same-cycle write DstReg=3 DstData=16'h00AA with SrcReg2=3, old value 16'h0011 -> SrcData2=16'h00AA with BYPASS_EN, 16'h0011 without.
REQ-032 SHALL cover: write all 16 registers with value 16'h1000+index over 16 cycles, read back via both ports -> each matches, Written=16'hFFFE (ZERO_R0=1).
REQ-033 SHALL cover: assert rst mid-clock-period after writes -> all SrcData, Wordline, Written read 0 immediately, before next edge.
REQ-034 SHALL cover: DATA_W=32, ADDR_W=5 instance, write DstReg=31 DstData=32'hDEADBEEF -> SrcData1=32'hDEADBEEF, Wordline=32'h80000000.
